hex_display_ctrl: RTL



---
 rtl/hex_display_ctrl.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/hex_display_ctrl.sv
// ---------------------------------------------------------------------------
// hex_display_ctrl
//
// Parametrised seven-segment controller for NUM_DIGITS hex digits.
// A load handshake captures a packed nibble word plus per-digit blank and
// blink masks, a display mode and a leading-zero suppression enable.
// Scroll mode rotates the digits left one position every SCROLL_DIV cycles.
// Blink mode darkens the digits selected by blink_mask on alternate
// BLINK_DIV-cycle phases. Segment outputs are registered.
//
// Pipeline: capture regs (_p0) on accept -> working regs (_p1) in the
// ACCEPT cycle (these rotate while scrolling) -> registered segs (_p2).
// A load accepted at edge N is visible on segs after edge N+2.
//
// Ports:
//   Clk        in   system clock
//   Reset      in   synchronous, active-high reset
//   load       in   request to capture load_data/masks/mode/lzs_en
//   ready      out  high when a load will be accepted this cycle
//   load_data  in   packed nibbles, digit 0 = bits [3:0] (rightmost)
//   blank_mask in   1 = digit forced dark
//   blink_mask in   1 = digit dark during blink phase 1
//   mode       in   00 static, 01 scroll-left, 10 blink, 11 scroll+blink
//   lzs_en     in   leading-zero suppression enable
//   dp_mask    in   (HEX_DP_EN only) 1 = decimal point lit
//   segs       out  {g,f,e,d,c,b,a} per digit (plus dp as bit 7 with
//                   HEX_DP_EN); digit i at bits [SEG_W*i +: SEG_W]
//   step_tick  out  one-cycle pulse on every scroll step
//
// Optional feature macro: HEX_DP_EN (decimal points, 8 bits per digit).
// ---------------------------------------------------------------------------
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25000000,
    parameter int SCROLL_DIV = 12500000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    load,
    output logic                    ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [1:0]              mode,
    input  logic                    lzs_en,
`ifdef HEX_DP_EN
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [8*NUM_DIGITS-1:0] segs,
`else
    output logic [7*NUM_DIGITS-1:0] segs,
`endif
    output logic                    step_tick
);

`ifdef HEX_DP_EN
    localparam int SEG_W = 8;
`else
    localparam int SEG_W = 7;
`endif
    localparam int SDIV_W = $clog2(SCROLL_DIV);
    localparam int BDIV_W = $clog2(BLINK_DIV);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        RUN    = 2'd2
    } state_t;

    // Segment pattern (active-high, {g,f,e,d,c,b,a}); b and d lowercase.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Left rotate by one digit: digit i <- digit i-1, digit 0 <- top digit.
    // The modulo form keeps NUM_DIGITS=1 legal (identity).
    function automatic logic [4*NUM_DIGITS-1:0] rotl_nib(input logic [4*NUM_DIGITS-1:0] d);
        logic [4*NUM_DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            r[4*i +: 4] = d[4*((i + NUM_DIGITS - 1) % NUM_DIGITS) +: 4];
        return r;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] rotl_bit(input logic [NUM_DIGITS-1:0] d);
        logic [NUM_DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            r[i] = d[(i + NUM_DIGITS - 1) % NUM_DIGITS];
        return r;
    endfunction

    state_t state, state_nxt;
    logic   accept;
    logic   scroll_step;
    logic   sdiv_term, bdiv_term;

    logic [4*NUM_DIGITS-1:0] data_p0, data_p1;
    logic [NUM_DIGITS-1:0]   blank_p0, blank_p1;
    logic [NUM_DIGITS-1:0]   blink_p0, blink_p1;
    logic [1:0]              mode_p0;
    logic                    blink_en_p1;
    logic                    lzs_p0, lzs_p1;
`ifdef HEX_DP_EN
    logic [NUM_DIGITS-1:0]   dp_p0, dp_p1;
`endif

    logic [SDIV_W-1:0] sdiv;
    logic [BDIV_W-1:0] bdiv;
    logic              phase;

    logic [SEG_W*NUM_DIGITS-1:0] segs_nxt;

    assign accept      = load && ready;
    assign sdiv_term   = (sdiv == SDIV_W'(SCROLL_DIV - 1));
    assign bdiv_term   = (bdiv == BDIV_W'(BLINK_DIV - 1));
    // A load on the terminal-count edge wins; that rotation is dropped.
    assign scroll_step = (state == RUN) && sdiv_term && !accept;

    // ---------------- FSM ----------------
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ACCEPT;
            ACCEPT:  state_nxt = mode_p0[0] ? RUN : IDLE;
            RUN:     if (accept) state_nxt = ACCEPT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = (state != ACCEPT);
    end

    // ---------------- stage p0: capture on accept ----------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            data_p0  <= '0;
            blank_p0 <= '0;
            blink_p0 <= '0;
            mode_p0  <= '0;
            lzs_p0   <= 1'b0;
`ifdef HEX_DP_EN
            dp_p0    <= '0;
`endif
        end else if (accept) begin
            data_p0  <= load_data;
            blank_p0 <= blank_mask;
            blink_p0 <= blink_mask;
            mode_p0  <= mode;
            lzs_p0   <= lzs_en;
`ifdef HEX_DP_EN
            dp_p0    <= dp_mask;
`endif
        end
    end

    // ---------------- stage p1: working registers (commit / rotate) ----------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            data_p1     <= '0;
            blank_p1    <= '0;
            blink_p1    <= '0;
            blink_en_p1 <= 1'b0;
            lzs_p1      <= 1'b0;
`ifdef HEX_DP_EN
            dp_p1       <= '0;
`endif
        end else if (state == ACCEPT) begin
            data_p1     <= data_p0;
            blank_p1    <= blank_p0;
            blink_p1    <= blink_p0;
            blink_en_p1 <= mode_p0[1];
            lzs_p1      <= lzs_p0;
`ifdef HEX_DP_EN
            dp_p1       <= dp_p0;
`endif
        end else if (scroll_step) begin
            data_p1  <= rotl_nib(data_p1);
            blank_p1 <= rotl_bit(blank_p1);
            blink_p1 <= rotl_bit(blink_p1);
`ifdef HEX_DP_EN
            dp_p1    <= rotl_bit(dp_p1);
`endif
        end
    end

    // Scroll divider only advances in RUN and restarts on every accepted load.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sdiv      <= '0;
            step_tick <= 1'b0;
        end else begin
            step_tick <= scroll_step;
            if (accept)
                sdiv <= '0;
            else if (state == RUN)
                sdiv <= sdiv_term ? '0 : sdiv + SDIV_W'(1);
        end
    end

    // Blink divider free-runs while blink is enabled; otherwise the count
    // is frozen and the phase is forced back to 0 (lit).
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bdiv  <= '0;
            phase <= 1'b0;
        end else if (blink_en_p1) begin
            if (bdiv_term) begin
                bdiv  <= '0;
                phase <= ~phase;
            end else begin
                bdiv <= bdiv + BDIV_W'(1);
            end
        end else begin
            phase <= 1'b0;
        end
    end

    // Decode from the working registers. Leading-zero scan runs from the
    // top digit down; digit 0 is never suppressed.
    always_comb begin
        logic             seen;
        logic [3:0]       nib;
        logic             lzs_dark;
        logic             dark;
        logic [6:0]       lit;
        logic [SEG_W-1:0] digit;
        seen     = 1'b0;
        nib      = '0;
        lzs_dark = 1'b0;
        dark     = 1'b0;
        lit      = '0;
        digit    = '0;
        segs_nxt = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib      = data_p1[4*i +: 4];
            seen     = seen | (nib != 4'h0);
            lzs_dark = lzs_p1 && (i != 0) && !seen;
            dark     = blank_p1[i] | (phase & blink_p1[i]) | lzs_dark;
            lit      = dark ? 7'h00 : hex_decode(nib);
`ifdef HEX_DP_EN
            digit    = {dp_p1[i] & ~dark, lit};
`else
            digit    = lit;
`endif
            segs_nxt[SEG_W*i +: SEG_W] = (ACTIVE_LOW != 0) ? ~digit : digit;
        end
    end

    // ---------------- stage p2: registered segment outputs ----------------
    always_ff @(posedge Clk) begin
        if (Reset) segs <= (ACTIVE_LOW != 0) ? '1 : '0;
        else       segs <= segs_nxt;
    end

endmodule
